// File: rtl/frame_streamer.sv
// frame_streamer
// Raster-order pixel source. Reads a stored frame from a synchronous frame
// memory (one-cycle read latency) and drives a pixel stream with frame/row
// markers, an optional inter-row gap and an issue stall.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    frame request, honoured only in IDLE
//   frame_column_size        pixels per row   (latched on accepted start)
//   frame_row_size           rows per frame   (latched on accepted start)
//   base_addr                first pixel addr (latched on accepted start)
//   row_gap                  idle cycles after each non-final row
//   stall                    blocks new reads; in-flight reads still emit
//   mem_rd_en/mem_addr       read request to frame memory
//   mem_rd_data              read data, one cycle after mem_rd_en
//   out_point/valid_out      pixel stream
//   sof/eol/eof              frame/row/frame-end markers, qualified by valid_out
//   busy                     frame in progress
//   done                     one-cycle completion pulse
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// STREAM | issuing one read per non-stalled cycle
// GAP    | inserting row_gap idle cycles between rows
// DRAIN  | all reads issued, waiting for the eof pixel to leave
module frame_streamer #(
  parameter int PIXEL_WIDTH   = 8,
  parameter int BUFFER_LENGTH = 2000,
  parameter int ADDR_WIDTH    = 22,
  localparam int SW           = $clog2(BUFFER_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SW-1:0]          frame_column_size,
  input  logic [SW-1:0]          frame_row_size,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [7:0]             row_gap,
  input  logic                   stall,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rd_data,
  output logic [PIXEL_WIDTH-1:0] out_point,
  output logic                   valid_out,
  output logic                   sof,
  output logic                   eol,
  output logic                   eof,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          cols_q, cols_d;
  logic [SW-1:0]          rows_q, rows_d;
  logic [SW-1:0]          col_q, col_d;
  logic [SW-1:0]          row_q, row_d;
  logic [7:0]             gap_len_q, gap_len_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   done_q, done_d;

  // issue-time sideband
  logic rd_en, iss_sof, iss_eol, iss_eof;
  logic last_col, last_row;

  // stage 1: aligned with mem_rd_data
  logic s1_valid_q, s1_sof_q, s1_eol_q, s1_eof_q;
  // stage 2: registered output
  logic                   valid_out_q, sof_q, eol_q, eof_q;
  logic [PIXEL_WIDTH-1:0] out_point_q;

  assign last_col = (col_q == cols_q - SW'(1));
  assign last_row = (row_q == rows_q - SW'(1));

  always_comb begin
    state_d   = state_q;
    cols_d    = cols_q;
    rows_d    = rows_q;
    col_d     = col_q;
    row_d     = row_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    iss_sof   = 1'b0;
    iss_eol   = 1'b0;
    iss_eof   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (frame_column_size != '0 && frame_row_size != '0) begin
            cols_d    = frame_column_size;
            rows_d    = frame_row_size;
            gap_len_d = row_gap;
            col_d     = '0;
            row_d     = '0;
            addr_d    = base_addr;
            state_d   = S_STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_STREAM: begin
        if (!stall) begin
          rd_en   = 1'b1;
          iss_sof = (col_q == '0) && (row_q == '0);
          iss_eol = last_col;
          iss_eof = last_col && last_row;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + SW'(1);
              if (gap_len_q != '0) begin
                // counter terminates at 0, so load one less than the gap
                gap_cnt_d = gap_len_q - 8'(1);
                state_d   = S_GAP;
              end
            end
          end else begin
            col_d = col_q + SW'(1);
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_STREAM;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'(1);
        end
      end

      S_DRAIN: begin
        if (valid_out_q && eof_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      valid_out_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      out_point_q <= '0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      rows_q      <= rows_d;
      col_q       <= col_d;
      row_q       <= row_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      s1_valid_q  <= rd_en;
      s1_sof_q    <= iss_sof;
      s1_eol_q    <= iss_eol;
      s1_eof_q    <= iss_eof;
      valid_out_q <= s1_valid_q;
      sof_q       <= s1_sof_q;
      eol_q       <= s1_eol_q;
      eof_q       <= s1_eof_q;
      if (s1_valid_q) begin
        out_point_q <= mem_rd_data;
      end
    end
  end

  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;
  assign out_point = out_point_q;
  assign valid_out = valid_out_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_frame_streamer.sv
module tb_frame_streamer;
  localparam int SW = 11;
  localparam int AW = 22;
  localparam int PW = 8;

  typedef struct {
    logic [AW-1:0] a;
    longint        c;
  } rd_t;

  typedef struct {
    logic [PW-1:0] p;
    logic          s;
    logic          e;
    logic          f;
    longint        c;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [SW-1:0] fcs = '0;
  logic [SW-1:0] frs = '0;
  logic [AW-1:0] base = '0;
  logic [7:0]    gap = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rd_data = '0;
  logic [PW-1:0] out_point;
  logic          valid_out, sof, eol, eof, busy, done;

  int     total = 0;
  int     bad = 0;
  longint cnt = 0;
  longint busy_lo = 1;
  longint busy_hi = 0;

  rd_t    rdq[$];
  pix_t   pxq[$];
  longint dnq[$];

  frame_streamer #(.PIXEL_WIDTH(PW), .BUFFER_LENGTH(2000), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .frame_column_size(fcs), .frame_row_size(frs),
    .base_addr(base), .row_gap(gap), .stall(stall),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_point(out_point), .valid_out(valid_out),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  function automatic logic [PW-1:0] pix_of(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[21:14] ^ 8'hA5;
  endfunction

  // frame memory: synchronous read, one-cycle latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= pix_of(mem_addr);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cnt);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: output seen with nothing expected (cycle %0d)", nm, cnt);
  endtask

  // monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    rd_t    r;
    pix_t   p;
    longint d;
    if (mem_rd_en) begin
      if (rdq.size() == 0) unexpected("rd_unexpected");
      else begin
        r = rdq.pop_front();
        chk("rd_addr", mem_addr, r.a);
        chk("rd_cycle", cnt, r.c);
      end
    end
    if (valid_out) begin
      if (pxq.size() == 0) unexpected("pix_unexpected");
      else begin
        p = pxq.pop_front();
        chk("pix_value", out_point, p.p);
        chk("pix_sof", sof, p.s);
        chk("pix_eol", eol, p.e);
        chk("pix_eof", eof, p.f);
        chk("pix_cycle", cnt, p.c);
      end
    end
    if (done) begin
      if (dnq.size() == 0) unexpected("done_unexpected");
      else begin
        d = dnq.pop_front();
        chk("done_cycle", cnt, d);
      end
    end
    chk("busy", busy, (cnt >= busy_lo && cnt <= busy_hi));
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_point"}, out_point, 0);
    chk({tag, "_sof"}, sof, 0);
    chk({tag, "_eol"}, eol, 0);
    chk({tag, "_eof"}, eof, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Start a frame at cycle 0 and push the expected reads, pixels and done.
  // slo..shi: stall window (cycles); abort_k: cycle rst is high (0 = none);
  // start2_k: cycle of an extra start with different parameters (0 = none).
  task automatic run_frame(input int C, input int R, input logic [AW-1:0] b, input int g,
                           input int slo, input int shi, input int abort_k, input int start2_k);
    longint        t0;
    int            k;
    int            last_iss;
    int            kend;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    start = 1'b1;
    fcs   = SW'(C);
    frs   = SW'(R);
    base  = b;
    gap   = 8'(g);
    t0    = cnt;
    k        = 1;
    last_iss = 0;
    if (C > 0 && R > 0) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          while (k >= slo && k <= shi) k++;
          a = b + AW'(r * C + c);
          if (abort_k == 0 || k <= abort_k)
            rdq.push_back('{a: a, c: t0 + k});
          if (abort_k == 0 || k + 2 <= abort_k)
            pxq.push_back('{p: pix_of(a), s: (r == 0 && c == 0), e: (c == C - 1),
                            f: (c == C - 1 && r == R - 1), c: t0 + k + 2});
          last_iss = k;
          k++;
          if (c == C - 1 && r != R - 1) k += g;
        end
      end
      busy_lo = t0 + 1;
      busy_hi = (abort_k != 0) ? t0 + abort_k : t0 + last_iss + 2;
      if (abort_k == 0) dnq.push_back(t0 + last_iss + 3);
    end else begin
      dnq.push_back(t0 + 1);
    end
    kend = (abort_k != 0) ? abort_k + 3 : last_iss + 6;
    for (int kk = 1; kk <= kend; kk++) begin
      @(posedge clk); #1;
      start = (kk == start2_k);
      if (kk == start2_k) begin
        fcs  = SW'(1);
        frs  = SW'(1);
        base = 22'h003000;
        gap  = 8'd5;
      end
      stall = (kk >= slo && kk <= shi);
      rst   = (kk == abort_k);
      if (abort_k != 0 && kk == abort_k + 1) chk_zero("abort");
    end
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b0;
    chk("rd_left", rdq.size(), 0);
    chk("pix_left", pxq.size(), 0);
    chk("done_left", dnq.size(), 0);
    rdq.delete();
    pxq.delete();
    dnq.delete();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(4, 3, 22'h000100, 0, 0, 0, 0, 0);  // basic: done at 15
    run_frame(4, 3, 22'h000100, 2, 0, 0, 0, 0);  // row gap: done at 19
    run_frame(4, 3, 22'h000100, 0, 6, 8, 0, 0);  // stall: done at 18
    run_frame(0, 5, 22'h000100, 0, 0, 0, 0, 0);  // zero size: done at 1
    run_frame(4, 3, 22'h000200, 0, 0, 0, 7, 5);  // ignored start + abort
    run_frame(4, 1, 22'h3FFFFE, 0, 0, 0, 0, 0);  // address wrap
    run_frame(1, 1, 22'h000055, 0, 0, 0, 0, 0);  // single pixel
    run_frame(3, 2, 22'h001000, 1, 3, 5, 0, 0);  // gap with stall

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
